// File: rtl/ones_window_ctrl_pkg.sv
// Shared state encoding and default widths for the consecutive-ones window measurement.
package ones_window_ctrl_pkg;

    localparam int DEF_WIN_W = 16;
    localparam int DEF_THR_W = 4;
    localparam int DEF_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ARM  = 2'b01,
        RUN  = 2'b10,
        DONE = 2'b11
    } state_t;

endpackage

// File: rtl/ones_run_counter.sv
// Run-length counter over data_in: combinational event on reaching threshold, registered detect.
// Zero latency on evt, one cycle on detect; no backpressure.
module ones_run_counter
    import ones_window_ctrl_pkg::*;
#(
    parameter int THR_W = DEF_THR_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic             data_in,
    input  logic [THR_W-1:0] threshold,
    output logic             evt,
    output logic             detect
);

    logic [THR_W-1:0] run;
    logic [THR_W-1:0] eff_thr;

    // A zero threshold would make every cycle an event; it behaves as one.
    always_comb begin
        eff_thr = (threshold == '0) ? THR_W'(1) : threshold;
    end

    assign evt = enable && data_in && (run == eff_thr - THR_W'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run    <= '0;
            detect <= 1'b0;
        end else if (clear) begin
            run    <= '0;
            detect <= 1'b0;
        end else if (enable) begin
            if (data_in) begin
                if (run != eff_thr) begin
                    run <= run + THR_W'(1);
                end
                detect <= (run >= eff_thr - THR_W'(1));
            end else begin
                run    <= '0;
                detect <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ones_window_ctrl.sv
// Window controller: counts qualifying runs of ones over window_len samples, reports with a done pulse.
// First sample two edges after start, done one cycle after the last sample; start while busy is dropped.
module ones_window_ctrl
    import ones_window_ctrl_pkg::*;
#(
    parameter int WIN_W = DEF_WIN_W,
    parameter int THR_W = DEF_THR_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIN_W-1:0] window_len,
    input  logic [THR_W-1:0] threshold,
    input  logic             data_in,
    output logic             busy,
    output logic             detect,
    output logic             done,
    output logic [CNT_W-1:0] count
);

    state_t           state;
    logic [WIN_W-1:0] win_len_q;
    logic [WIN_W-1:0] remaining;
    logic [THR_W-1:0] thr_q;
    logic             run_en;
    logic             run_clear;
    logic             run_evt;
    logic             last_sample;

    assign run_en      = (state == RUN);
    assign last_sample = run_en && (remaining == WIN_W'(1));
    // Clearing on the last sample lets detect read 0 in DONE; the final event still reaches count.
    assign run_clear   = (state == ARM) || last_sample;

    ones_run_counter #(
        .THR_W (THR_W)
    ) u_run (
        .clk       (clk),
        .reset     (reset),
        .clear     (run_clear),
        .enable    (run_en),
        .data_in   (data_in),
        .threshold (thr_q),
        .evt       (run_evt),
        .detect    (detect)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            win_len_q <= '0;
            thr_q     <= '0;
            remaining <= '0;
            count     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        win_len_q <= window_len;
                        thr_q     <= threshold;
                        busy      <= 1'b1;
                        state     <= ARM;
                    end
                end
                ARM: begin
                    remaining <= win_len_q;
                    count     <= '0;
                    if (win_len_q == '0) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    remaining <= remaining - WIN_W'(1);
                    if (run_evt && (count != '1)) begin
                        count <= count + CNT_W'(1);
                    end
                    if (last_sample) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ones_window_ctrl.sv
// Bench for ones_window_ctrl: per-cycle timeline model plus literal end-of-window expectations.
module tb_ones_window_ctrl;
    import ones_window_ctrl_pkg::*;

    localparam int WIN_W = 16;
    localparam int THR_W = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [WIN_W-1:0] window_len;
    logic [THR_W-1:0] threshold;
    logic             data_in;
    logic             busy;
    logic             detect;
    logic             done;
    logic [CNT_W-1:0] count;

    int tests = 0;
    int fails = 0;

    logic             chk_en     = 1'b0;
    logic             exp_busy   = 1'b0;
    logic             exp_done   = 1'b0;
    logic             exp_detect = 1'b0;
    logic [CNT_W-1:0] exp_count  = '0;
    int               done_seen  = 0;
    int               det_seen   = 0;
    bit               stim[$];

    ones_window_ctrl #(
        .WIN_W (WIN_W),
        .THR_W (THR_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .window_len (window_len),
        .threshold  (threshold),
        .data_in    (data_in),
        .busy       (busy),
        .detect     (detect),
        .done       (done),
        .count      (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",   {31'd0, busy},   {31'd0, exp_busy});
            check("done",   {31'd0, done},   {31'd0, exp_done});
            check("detect", {31'd0, detect}, {31'd0, exp_detect});
            check("count",  {24'd0, count},  {24'd0, exp_count});
        end
        if (done === 1'b1)   done_seen++;
        if (detect === 1'b1) det_seen++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one whole measurement from stim[] and sets the expected outputs for each cycle.
    task automatic run_meas(input int wl, input int thr, input int start_at);
        int eff;
        int runlen;
        int cnt;
        bit det_prev;
        eff       = (thr == 0) ? 1 : thr;
        done_seen = 0;
        det_seen  = 0;
        start      = 1'b1;
        window_len = WIN_W'(wl);
        threshold  = THR_W'(thr);
        exp_busy   = 1'b0;
        exp_done   = 1'b0;
        exp_detect = 1'b0;
        tick();
        start      = 1'b0;
        window_len = WIN_W'($urandom);
        threshold  = THR_W'($urandom);
        exp_busy   = 1'b1;
        tick();
        exp_count = '0;
        runlen    = 0;
        cnt       = 0;
        det_prev  = 1'b0;
        for (int i = 0; i < wl; i++) begin
            data_in    = stim[i];
            start      = (i == start_at);
            exp_detect = det_prev;
            exp_count  = CNT_W'(cnt);
            tick();
            runlen = stim[i] ? runlen + 1 : 0;
            if (runlen == eff && cnt < 255) cnt++;
            det_prev = (runlen >= eff);
        end
        start      = 1'b0;
        data_in    = 1'b0;
        exp_done   = 1'b1;
        exp_detect = 1'b0;
        exp_count  = CNT_W'(cnt);
        tick();
        exp_done = 1'b0;
        exp_busy = 1'b0;
        tick();
    endtask

    task automatic load_bits(input string s);
        stim.delete();
        for (int i = 0; i < s.len(); i++) stim.push_back(s[i] == "1");
    endtask

    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        data_in    = 1'b0;
        window_len = '0;
        threshold  = '0;
        chk_en     = 1'b1;
        tick();
        tick();
        check("rst_count", {24'd0, count}, 32'd0);
        check("rst_busy",  {31'd0, busy},  32'd0);
        reset = 1'b1;
        tick();

        load_bits("1110111100");
        run_meas(10, 3, -1);
        check("t2_count", {24'd0, count}, 32'd2);
        check("t2_det_cycles", det_seen, 3);
        check("t2_done_pulses", done_seen, 1);

        load_bits("11111111");
        run_meas(8, 3, -1);
        check("t3_count", {24'd0, count}, 32'd1);
        check("t3_det_cycles", det_seen, 5);
        check("t3_done_pulses", done_seen, 1);

        load_bits("");
        run_meas(0, 3, -1);
        check("t4_count", {24'd0, count}, 32'd0);
        check("t4_done_pulses", done_seen, 1);

        load_bits("10101");
        run_meas(5, 0, -1);
        check("t5_count", {24'd0, count}, 32'd3);

        stim.delete();
        for (int i = 0; i < 600; i++) stim.push_back(i % 2 == 0);
        run_meas(600, 1, -1);
        check("t6_count_sat", {24'd0, count}, 32'd255);

        load_bits("0110110111");
        run_meas(10, 2, 4);
        check("t7_count", {24'd0, count}, 32'd3);
        check("t7_done_pulses", done_seen, 1);

        // Abort a 20-sample window after five ones.
        chk_en     = 1'b0;
        start      = 1'b1;
        window_len = 16'd20;
        threshold  = 4'd3;
        tick();
        start = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            data_in = 1'b1;
            tick();
        end
        check("t8_pre_count", {24'd0, count}, 32'd1);
        done_seen = 0;
        #2;
        reset = 1'b0;
        #1;
        check("t8_busy",   {31'd0, busy},   32'd0);
        check("t8_detect", {31'd0, detect}, 32'd0);
        check("t8_done",   {31'd0, done},   32'd0);
        check("t8_count",  {24'd0, count},  32'd0);
        check("t8_state",  {30'd0, dut.state}, {30'd0, IDLE});
        data_in = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        tick();
        check("t8_no_done", done_seen, 0);
        exp_busy   = 1'b0;
        exp_done   = 1'b0;
        exp_detect = 1'b0;
        exp_count  = '0;
        chk_en     = 1'b1;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
